// File: rtl/noc_axis_pkg.sv
// Shared types and helpers for the AXI-Stream packet arbiters.
package noc_axis_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int unsigned MAX_SRC   = 8;
  localparam int unsigned MAX_IDX_W = 3;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // First requester strictly after 'last', wrapping modulo n; returns 'last' when nobody requests.
  function automatic logic [MAX_IDX_W-1:0] rr_pick(
    input logic [MAX_SRC-1:0]   req,
    input logic [MAX_IDX_W-1:0] last,
    input int unsigned          n
  );
    logic [MAX_IDX_W-1:0] pick;
    logic                 found;
    int unsigned          idx;
    pick  = last;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_SRC; k++) begin
      if (k <= n) begin
        idx = (32'(last) + k) % n;
        if (!found && req[idx[MAX_IDX_W-1:0]]) begin
          pick  = idx[MAX_IDX_W-1:0];
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_pick_comb.sv
// Combinational rotate-priority encoder: request vector + last grant -> next index and valid.
module rr_pick_comb
  import noc_axis_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  always_comb begin
    idx_o   = IW'(rr_pick(MAX_SRC'(req), MAX_IDX_W'(last), N));
    valid_o = |req;
  end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-level round-robin AXI-Stream arbiter with beat-limit watchdog and TID stamping.
module axis_pkt_arbiter
  import noc_axis_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned TDATAW    = 32,
  parameter int unsigned TDESTW    = 4,
  parameter int unsigned TIDW      = 2,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [NUM_SRC-1:0]        AXIS_S_TVALID,
  output logic [NUM_SRC-1:0]        AXIS_S_TREADY,
  input  logic [NUM_SRC*TDATAW-1:0] AXIS_S_TDATA,
  input  logic [NUM_SRC-1:0]        AXIS_S_TLAST,
  input  logic [NUM_SRC*TDESTW-1:0] AXIS_S_TDEST,
  output logic                      AXIS_M_TVALID,
  input  logic                      AXIS_M_TREADY,
  output logic [TDATAW-1:0]         AXIS_M_TDATA,
  output logic                      AXIS_M_TLAST,
  output logic [TIDW-1:0]           AXIS_M_TID,
  output logic [TDESTW-1:0]         AXIS_M_TDEST,
  output logic [NUM_SRC-1:0]        GRANT_O,
  output logic                      TIMEOUT_O
);

  localparam int unsigned IW   = idx_width(NUM_SRC);
  localparam int unsigned CNTW = $clog2(MAX_BEATS + 1);
  localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(MAX_BEATS - 1);

  arb_state_t         state_q, state_d;
  logic [IW-1:0]      grant_q, grant_d;
  logic [IW-1:0]      last_grant_q, last_grant_d;
  logic [CNTW-1:0]    beat_cnt_q, beat_cnt_d;
  logic [NUM_SRC-1:0] grant_oh_q, grant_oh_d;
  logic               timeout_q, timeout_d;

  logic [IW-1:0] pick_idx;
  logic          pick_valid;
  logic          src_valid, src_last, at_limit, accept;

  rr_pick_comb #(
    .N  (NUM_SRC),
    .IW (IW)
  ) u_pick (
    .req     (AXIS_S_TVALID),
    .last    (last_grant_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IW'(NUM_SRC - 1);
      beat_cnt_q   <= '0;
      grant_oh_q   <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      grant_oh_q   <= grant_oh_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    src_valid = AXIS_S_TVALID[grant_q];
    src_last  = AXIS_S_TLAST[grant_q];
    at_limit  = (beat_cnt_q == LAST_BEAT);
    accept    = (state_q == BUSY) && src_valid && AXIS_M_TREADY;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    grant_oh_d   = grant_oh_q;
    timeout_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d              = BUSY;
          grant_d              = pick_idx;
          beat_cnt_d           = '0;
          grant_oh_d           = '0;
          grant_oh_d[pick_idx] = 1'b1;
        end
      end
      BUSY: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          // Source TLAST takes precedence, so a packet ending exactly at the limit is not a timeout.
          if (src_last || at_limit) begin
            state_d      = IDLE;
            last_grant_d = grant_q;
            grant_oh_d   = '0;
            timeout_d    = !src_last;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    AXIS_M_TVALID = 1'b0;
    AXIS_M_TDATA  = '0;
    AXIS_M_TDEST  = '0;
    AXIS_M_TLAST  = 1'b0;
    AXIS_M_TID    = '0;
    AXIS_S_TREADY = '0;
    if (state_q == BUSY) begin
      AXIS_M_TVALID          = src_valid;
      AXIS_M_TDATA           = AXIS_S_TDATA[grant_q*TDATAW +: TDATAW];
      AXIS_M_TDEST           = AXIS_S_TDEST[grant_q*TDESTW +: TDESTW];
      AXIS_M_TLAST           = src_last | at_limit;
      AXIS_M_TID             = TIDW'(grant_q);
      AXIS_S_TREADY[grant_q] = AXIS_M_TREADY;
    end
    GRANT_O   = grant_oh_q;
    TIMEOUT_O = timeout_q;
  end

endmodule
